scalar_wb_arbiter: RTL and testbench
====================================

Name: scalar_wb_arbiter

Overview:
- Writeback arbiter directly upstream of the scalar register file.
- Merges two sources into the regfile's single write port (wr_reg, write_data_sca, reg_write):
  - in-order scalar pipeline results (ALU/load);
  - asynchronous vector-to-scalar results (vmv.x.s, vcpop.m, vfirst.m), which are buffered in a small FIFO.
- Keeps a per-register pending scoreboard so decode can stall on outstanding vector-to-scalar destinations.

Parameters:
- XLEN, 32, data width of scalar registers.
- FIFO_DEPTH, 4, vector-result FIFO entries; power of two, at least 2.
- STARVE_LIMIT, 8, consecutive cycles a non-empty FIFO may lose arbitration before stall_req is raised.

Ports:
- clk  input  1  clock
- rst  input  1  asynchronous reset, active-low
- wb_valid  input  1  scalar pipeline writeback valid; no backpressure
- wb_rd  input  5  scalar writeback destination
- wb_data  input  XLEN  scalar writeback data
- vs_valid  input  1  vector-to-scalar result valid
- vs_ready  output  1  FIFO can accept a result
- vs_rd  input  5  vector-to-scalar destination
- vs_data  input  XLEN  vector-to-scalar data
- issue_valid  input  1  decode issued a vector-to-scalar op
- issue_rd  input  5  destination of the issued op
- reg_write  output  1  regfile write enable
- wr_reg  output  5  regfile write address
- write_data_sca  output  XLEN  regfile write data
- busy_mask  output  32  bit i set means xi has an outstanding vector-to-scalar write
- stall_req  output  1  request to stall the scalar pipeline so the FIFO can drain

Behaviour:
- Reset (rst low, async):
  - reg_write, wr_reg, write_data_sca, busy_mask, stall_req all 0.
  - FIFO pointers and count 0; starve counter 0.
  - vs_ready = 1 once the FIFO is empty.
  - Reset mid-operation discards all FIFO contents and pending bits.
- vs_ready = (count != FIFO_DEPTH), derived from the registered count only. No same-cycle pop-to-push pass-through.
- Push occurs when vs_valid && vs_ready; vs_valid while full is held off and nothing is lost.
- Arbitration, evaluated each cycle:
  - wb_valid wins unconditionally.
  - Otherwise the FIFO head pops when count != 0.
  - At most one source is selected per cycle.
- Output timing:
  - The selected source is registered onto wr_reg/write_data_sca; reg_write is asserted the following cycle. Latency is exactly 1 cycle from wb_valid, or from the arbitration cycle for the FIFO head.
  - When nothing is selected, reg_write = 0 and wr_reg/write_data_sca hold their previous values.
- x0 handling:
  - A selected source with rd = 0 yields reg_write = 0; a FIFO entry with rd 0 is still popped.
  - issue_rd = 0 never sets busy.
- Simultaneous push and pop: count is unchanged; pointers wrap modulo FIFO_DEPTH.
- Starve counter:
  - Increments when count != 0 and wb_valid wins.
  - Resets to 0 on any pop or when count == 0.
  - Saturates at STARVE_LIMIT.
- stall_req (registered):
  - Next state = (count == FIFO_DEPTH) or (starve counter == STARVE_LIMIT).
  - Cleared the cycle after the condition goes false.
  - If wb_valid still arrives while stall_req is high, the scalar write still wins.
- busy_mask (registered):
  - Set: issue_valid && issue_rd != 0 sets bit issue_rd next cycle.
  - Clear: a FIFO pop with rd != 0 clears bit rd next cycle.
  - Set and clear of the same bit in the same cycle: set wins.
  - Decode must not issue to an already-busy rd.
  - A scalar writeback to a busy rd writes normally and leaves busy unchanged.

Test Plan:
- Reset, then wb_valid=1, wb_rd=5, wb_data=0xDEADBEEF for one cycle -> next cycle reg_write=1, wr_reg=5, write_data_sca=0xDEADBEEF; the following cycle reg_write=0.
- Scalar priority:
  - Stimulus: issue_rd=7, then vs push (rd=7, data=0x11) while wb_valid is held high 3 cycles to rd=1,2,3.
  - Required: writes appear in order x1, x2, x3, then x7=0x11; busy_mask[7] is 1 throughout and clears the cycle x7 is written.
- FIFO full:
  - Stimulus: hold wb_valid high; push 4 vs results (rd 8..11).
  - Required: vs_ready=0 after the 4th push; stall_req=1 the next cycle.
  - Then drop wb_valid: entries drain in order 8, 9, 10, 11 over 4 cycles; vs_ready returns to 1 after the first pop.
- Starvation:
  - Stimulus: one FIFO entry; wb_valid high continuously.
  - Required: stall_req rises after 8 lost cycles; the entry is written the cycle after wb_valid drops; stall_req then clears.
- x0 and busy set/clear collision:
  - Stimulus: vs push with rd=0.
  - Required: popped with no reg_write.
  - Stimulus: issue_rd=4 in the same cycle as a FIFO pop of rd=4.
  - Required: busy_mask[4] stays 1.
- Async reset mid-drain:
  - Stimulus: rst low with 3 entries queued and busy bits set.
  - Required: immediately busy_mask=0, reg_write=0, stall_req=0; after release vs_ready=1 and no stale writes occur.

Source files
------------

// File: rtl/scalar_wb_arbiter.sv
// Scalar register-file writeback arbiter: merges in-order scalar results with
// buffered vector-to-scalar results and tracks outstanding vector-to-scalar rds.
module scalar_wb_arbiter #(
    parameter int XLEN         = 32,
    parameter int FIFO_DEPTH   = 4,
    parameter int STARVE_LIMIT = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            wb_valid,
    input  logic [4:0]      wb_rd,
    input  logic [XLEN-1:0] wb_data,
    input  logic            vs_valid,
    output logic            vs_ready,
    input  logic [4:0]      vs_rd,
    input  logic [XLEN-1:0] vs_data,
    input  logic            issue_valid,
    input  logic [4:0]      issue_rd,
    output logic            reg_write,
    output logic [4:0]      wr_reg,
    output logic [XLEN-1:0] write_data_sca,
    output logic [31:0]     busy_mask,
    output logic            stall_req
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int STV_W = $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] FULL_CNT   = CNT_W'(FIFO_DEPTH);
    localparam logic [STV_W-1:0] STARVE_MAX = STV_W'(STARVE_LIMIT);

    typedef struct packed {
        logic [4:0]      rd;
        logic [XLEN-1:0] data;
    } vs_entry_t;

    vs_entry_t        fifo_mem [FIFO_DEPTH];
    vs_entry_t        head;
    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic [CNT_W-1:0] count;
    logic [STV_W-1:0] starve_cnt;

    logic             fifo_empty, fifo_full;
    logic             push, pop;
    logic             sel_valid;
    logic [4:0]       sel_rd;
    logic [XLEN-1:0]  sel_data;
    logic [31:0]      busy_set, busy_clr;

    // Readiness comes only from the registered count, so a pop never frees
    // a slot for a push in the same cycle.
    assign fifo_empty = (count == '0);
    assign fifo_full  = (count == FULL_CNT);
    assign vs_ready   = !fifo_full;
    assign push       = vs_valid && !fifo_full;
    assign pop        = !wb_valid && !fifo_empty;
    assign head       = fifo_mem[rd_ptr];

    always_comb begin
        sel_valid = 1'b0;
        sel_rd    = '0;
        sel_data  = '0;
        if (wb_valid) begin
            sel_valid = 1'b1;
            sel_rd    = wb_rd;
            sel_data  = wb_data;
        end else if (pop) begin
            sel_valid = 1'b1;
            sel_rd    = head.rd;
            sel_data  = head.data;
        end
    end

    always_comb begin
        busy_set = '0;
        busy_clr = '0;
        if (issue_valid && issue_rd != 5'd0)
            busy_set = 32'(1) << issue_rd;
        if (pop && head.rd != 5'd0)
            busy_clr = 32'(1) << head.rd;
    end

    // Storage carries no reset; validity is defined by the pointers/count.
    always_ff @(posedge clk) begin
        if (push)
            fifo_mem[wr_ptr] <= '{rd: vs_rd, data: vs_data};
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)
                rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Counts cycles a non-empty FIFO loses to the scalar pipeline.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            starve_cnt <= '0;
            stall_req  <= 1'b0;
        end else begin
            if (fifo_empty || pop)
                starve_cnt <= '0;
            else if (wb_valid && starve_cnt != STARVE_MAX)
                starve_cnt <= starve_cnt + STV_W'(1);
            stall_req <= fifo_full || (starve_cnt == STARVE_MAX);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            reg_write      <= 1'b0;
            wr_reg         <= '0;
            write_data_sca <= '0;
        end else begin
            reg_write <= sel_valid && (sel_rd != 5'd0);
            if (sel_valid) begin
                wr_reg         <= sel_rd;
                write_data_sca <= sel_data;
            end
        end
    end

    // Set beats clear so a reissue to the popped rd stays pending.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            busy_mask <= '0;
        else
            busy_mask <= (busy_mask & ~busy_clr) | busy_set;
    end

endmodule

// File: tb/tb_scalar_wb_arbiter.sv
// Directed bench for scalar_wb_arbiter; expected regfile writes are queued as
// stimulus is driven and compared as reg_write pulses appear.
module tb_scalar_wb_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        wb_valid, vs_valid, issue_valid;
    logic [4:0]  wb_rd, vs_rd, issue_rd;
    logic [31:0] wb_data, vs_data;
    logic        vs_ready, reg_write, stall_req;
    logic [4:0]  wr_reg;
    logic [31:0] write_data_sca, busy_mask;

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] data;
    } wr_t;

    wr_t exp_q[$];
    int  total = 0;
    int  bad   = 0;

    scalar_wb_arbiter #(.XLEN(32), .FIFO_DEPTH(4), .STARVE_LIMIT(8)) dut (
        .clk(clk), .rst(rst),
        .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
        .vs_valid(vs_valid), .vs_ready(vs_ready), .vs_rd(vs_rd), .vs_data(vs_data),
        .issue_valid(issue_valid), .issue_rd(issue_rd),
        .reg_write(reg_write), .wr_reg(wr_reg), .write_data_sca(write_data_sca),
        .busy_mask(busy_mask), .stall_req(stall_req)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_wr(input logic [4:0] rd, input logic [31:0] data);
        wr_t e;
        e.rd   = rd;
        e.data = data;
        exp_q.push_back(e);
    endtask

    // Every reg_write pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (reg_write) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_write", {59'd0, wr_reg}, 64'hFFFF);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                chk("wr_reg", {59'd0, wr_reg}, {59'd0, e.rd});
                chk("wr_data", {32'd0, write_data_sca}, {32'd0, e.data});
            end
        end
    end

    initial begin
        rst = 1'b0;
        wb_valid = 0; wb_rd = 0; wb_data = 0;
        vs_valid = 0; vs_rd = 0; vs_data = 0;
        issue_valid = 0; issue_rd = 0;
        tick(); tick();
        chk("rst_reg_write", 64'(reg_write), 64'd0);
        chk("rst_wr_reg", 64'(wr_reg), 64'd0);
        chk("rst_wdata", 64'(write_data_sca), 64'd0);
        chk("rst_busy", 64'(busy_mask), 64'd0);
        chk("rst_stall", 64'(stall_req), 64'd0);
        chk("rst_vs_ready", 64'(vs_ready), 64'd1);
        rst = 1'b1;
        tick();

        // Single scalar writeback, one-cycle latency
        wb_valid = 1; wb_rd = 5; wb_data = 32'hDEADBEEF;
        expect_wr(5, 32'hDEADBEEF);
        tick();
        wb_valid = 0;
        chk("t1_reg_write", 64'(reg_write), 64'd1);
        chk("t1_wr_reg", 64'(wr_reg), 64'd5);
        tick();
        chk("t1_reg_write_off", 64'(reg_write), 64'd0);

        // Scalar priority over a queued vector result
        issue_valid = 1; issue_rd = 7;
        tick();
        issue_valid = 0;
        chk("t2_busy7_set", 64'(busy_mask[7]), 64'd1);
        vs_valid = 1; vs_rd = 7; vs_data = 32'h11;
        wb_valid = 1; wb_rd = 1; wb_data = 32'hA1; expect_wr(1, 32'hA1);
        tick();
        vs_valid = 0;
        chk("t2_busy7_a", 64'(busy_mask[7]), 64'd1);
        wb_rd = 2; wb_data = 32'hA2; expect_wr(2, 32'hA2);
        tick();
        chk("t2_busy7_b", 64'(busy_mask[7]), 64'd1);
        wb_rd = 3; wb_data = 32'hA3; expect_wr(3, 32'hA3);
        tick();
        chk("t2_busy7_c", 64'(busy_mask[7]), 64'd1);
        wb_valid = 0; expect_wr(7, 32'h11);
        tick();
        chk("t2_busy7_clr", 64'(busy_mask[7]), 64'd0);
        chk("t2_x7_write", 64'(reg_write), 64'd1);
        tick();

        // FIFO fills while the scalar pipe holds the port
        wb_valid = 1;
        for (int i = 0; i < 4; i++) begin
            wb_rd = 5'(20 + i); wb_data = 32'h200 + i; expect_wr(5'(20 + i), 32'h200 + i);
            vs_valid = 1; vs_rd = 5'(8 + i); vs_data = 32'h80 + i;
            tick();
        end
        vs_valid = 0;
        chk("t3_not_ready", 64'(vs_ready), 64'd0);
        wb_rd = 24; wb_data = 32'h204; expect_wr(24, 32'h204);
        tick();
        chk("t3_stall_full", 64'(stall_req), 64'd1);
        wb_valid = 0;
        for (int i = 0; i < 4; i++) expect_wr(5'(8 + i), 32'h80 + i);
        tick();
        chk("t3_ready_back", 64'(vs_ready), 64'd1);
        tick();
        chk("t3_stall_clr", 64'(stall_req), 64'd0);
        tick(); tick(); tick();
        chk("t3_drained", 64'(reg_write), 64'd0);

        // Starvation raises stall_req after STARVE_LIMIT lost cycles
        vs_valid = 1; vs_rd = 12; vs_data = 32'hC0;
        wb_valid = 1; wb_rd = 13;
        for (int i = 0; i < 9; i++) begin
            wb_data = 32'(i); expect_wr(13, 32'(i));
            tick();
            vs_valid = 0;
        end
        chk("t4_stall_early", 64'(stall_req), 64'd0);
        wb_data = 32'h9; expect_wr(13, 32'h9);
        tick();
        chk("t4_stall_rise", 64'(stall_req), 64'd1);
        wb_valid = 0; expect_wr(12, 32'hC0);
        tick();
        chk("t4_entry_write", 64'(wr_reg), 64'd12);
        tick();
        chk("t4_stall_clear", 64'(stall_req), 64'd0);

        // x0 entry pops silently; set/clear collision keeps busy
        vs_valid = 1; vs_rd = 0; vs_data = 32'h55;
        tick();
        vs_rd = 4; vs_data = 32'h44;
        tick();
        vs_valid = 0;
        chk("t5_x0_no_write", 64'(reg_write), 64'd0);
        issue_valid = 1; issue_rd = 4; expect_wr(4, 32'h44);
        tick();
        issue_valid = 0;
        chk("t5_x4_write", 64'(reg_write), 64'd1);
        chk("t5_busy4_kept", 64'(busy_mask[4]), 64'd1);
        tick();

        // Async reset with queued entries and pending busy bits
        for (int i = 0; i < 3; i++) begin
            issue_valid = 1; issue_rd = 5'(14 + i);
            tick();
        end
        issue_valid = 0;
        wb_valid = 1; wb_rd = 17;
        for (int i = 0; i < 3; i++) begin
            wb_data = 32'h170 + i; expect_wr(17, 32'h170 + i);
            vs_valid = 1; vs_rd = 5'(14 + i); vs_data = 32'hE0 + i;
            tick();
        end
        vs_valid = 0; wb_valid = 0;
        tick();
        chk("t6_busy_pre", 64'(busy_mask[16:15]), 64'd3);
        rst = 1'b0;
        #1;
        chk("t6_busy_rst", 64'(busy_mask), 64'd0);
        chk("t6_wr_rst", 64'(reg_write), 64'd0);
        chk("t6_stall_rst", 64'(stall_req), 64'd0);
        exp_q.delete();
        tick(); tick();
        rst = 1'b1;
        tick();
        chk("t6_ready_after", 64'(vs_ready), 64'd1);
        repeat (6) tick();
        chk("t6_busy_after", 64'(busy_mask), 64'd0);
        chk("exp_q_empty", 64'(exp_q.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
